// File: rtl/dmem_lsu_mem_pkg.sv
// Shared types and constants for the load/store data memory.
package dmem_lsu_mem_pkg;

    localparam int DMEM_DEPTH_WORDS = 4096;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'b00,
        MEM_HALF    = 2'b01,
        MEM_WORD    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_size_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        mem_size_t   size;
        logic        is_unsigned;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_lsu_mem_if.sv
// Request/response handshake bundle between the mem stage and the data memory.
interface dmem_lsu_mem_if
    import dmem_lsu_mem_pkg::*;
    ;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic        req_we_i;
    mem_size_t   req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i,
               req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i,
               req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/dmem_lsu_mem_lane_align.sv
// Combinational sub-word steering: store byte-enables/replicated data,
// load lane select with sign/zero extension, and alignment/size error.
module dmem_lsu_mem_lane_align
    import dmem_lsu_mem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  mem_size_t   size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Decode size/alignment into lane enables, store data and extended load data.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = '0;
        rdata_o = '0;
        err_o   = 1'b0;
        unique case (size_i)
            MEM_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            end
            MEM_HALF: begin
                err_o   = addr_lo_i[0];
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            end
            MEM_WORD: begin
                err_o   = (addr_lo_i != 2'b00);
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rword_i;
            end
            default: begin
                err_o = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/dmem_lsu_mem.sv
// Word-organised data memory with valid/ready handshake, configurable access
// latency and RISC-V sub-word load/store; one request outstanding at a time.
module dmem_lsu_mem
    import dmem_lsu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int LATENCY     = 1,
    parameter int DATA_W      = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    dmem_lsu_mem_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("dmem_lsu_mem: DATA_W must be 32");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_lsu_mem: LATENCY must be at least 1");
    end
    if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
        $error("dmem_lsu_mem: DEPTH_WORDS must be a power of 2");
    end

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t         req_q;
    dmem_req_t         req_in;
    dmem_req_t         acc;
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              fire;
    logic              do_access;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_rdata;
    logic              al_err;
    logic              unused_addr_bits;

    assign req_in = '{addr:        bus.req_addr_i,
                      we:          bus.req_we_i,
                      size:        bus.req_size_i,
                      is_unsigned: bus.req_unsigned_i,
                      wdata:       bus.req_wdata_i};

    // With LATENCY=1 the access happens in the acceptance cycle, before the
    // request has been captured, so the live request feeds the datapath then.
    assign acc  = (state_q == ST_IDLE) ? req_in : req_q;
    assign idx  = acc.addr[2 +: IDX_W];
    assign fire = bus.req_valid_i && bus.req_ready_o;
    assign unused_addr_bits = ^acc.addr[31:2+IDX_W];

    dmem_lsu_mem_lane_align u_align (
        .addr_lo_i  (acc.addr[1:0]),
        .size_i     (acc.size),
        .unsigned_i (acc.is_unsigned),
        .wdata_i    (acc.wdata),
        .rword_i    (mem_q[idx]),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .err_o      (al_err)
    );

    // Next-state logic; the counter holds the cycles left until the response,
    // so the access is performed in the BUSY cycle where it reads 1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    cnt_d = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        do_access = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d   = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the accepted request for multi-cycle accesses.
    always_ff @(posedge clk_i) begin
        if (fire && !rst_i) req_q <= req_in;
    end

    // Response registers, loaded at the edge that enters RESP and held there.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (do_access) begin
            rdata_q <= (acc.we || al_err) ? '0 : al_rdata;
            err_q   <= al_err;
        end
    end

    // Storage array: cleared on reset, lane-masked write on a good store.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < DEPTH_WORDS; w++) mem_q[w] <= '0;
        end else if (do_access && acc.we && !al_err) begin
            for (int i = 0; i < 4; i++) begin
                if (al_be[i]) mem_q[idx][8*i +: 8] <= al_wdata[8*i +: 8];
            end
        end
    end

    assign bus.req_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign bus.rsp_valid_o = (state_q == ST_RESP) && !rst_i;
    assign bus.rsp_rdata_o = rst_i ? '0 : rdata_q;
    assign bus.rsp_err_o   = err_q && !rst_i;
endmodule

// File: tb/tb_dmem_lsu_mem.sv
// Directed bench: a LATENCY=1 and a LATENCY=4 instance sharing one stimulus
// bus, selected by sel; vector table for sub-word behaviour, hand sequences
// for backpressure and reset during BUSY.
module tb_dmem_lsu_mem;
    import dmem_lsu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic        uns = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_ready = 1'b1;

    dmem_lsu_mem_if bus1 ();
    dmem_lsu_mem_if bus4 ();

    assign bus1.req_valid_i    = req_valid & ~sel;
    assign bus1.req_addr_i     = addr;
    assign bus1.req_we_i       = we;
    assign bus1.req_size_i     = mem_size_t'(size);
    assign bus1.req_unsigned_i = uns;
    assign bus1.req_wdata_i    = wdata;
    assign bus1.rsp_ready_i    = rsp_ready;
    assign bus4.req_valid_i    = req_valid & sel;
    assign bus4.req_addr_i     = addr;
    assign bus4.req_we_i       = we;
    assign bus4.req_size_i     = mem_size_t'(size);
    assign bus4.req_unsigned_i = uns;
    assign bus4.req_wdata_i    = wdata;
    assign bus4.rsp_ready_i    = rsp_ready;

    dmem_lsu_mem #(.DEPTH_WORDS(4096), .LATENCY(1), .DATA_W(32)) u_dut1 (
        .clk_i (clk), .rst_i (rst), .bus (bus1.slave));
    dmem_lsu_mem #(.DEPTH_WORDS(4096), .LATENCY(4), .DATA_W(32)) u_dut4 (
        .clk_i (clk), .rst_i (rst), .bus (bus4.slave));

    logic        m_ready, m_valid, m_err;
    logic [31:0] m_rdata;
    assign m_ready = sel ? bus4.req_ready_o : bus1.req_ready_o;
    assign m_valid = sel ? bus4.rsp_valid_o : bus1.rsp_valid_o;
    assign m_rdata = sel ? bus4.rsp_rdata_o : bus1.rsp_rdata_o;
    assign m_err   = sel ? bus4.rsp_err_o   : bus1.rsp_err_o;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One request with rsp_ready held high; returns data, error and latency.
    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        we = w; size = sz; uns = u; addr = a; wdata = wd;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        n = 0;
        while (!m_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        rd = 'x; e = 1'bx; lat = -1;
        if (!m_ready) begin
            req_valid = 1'b0;
            chk("req_ready timeout", {31'b0, m_ready}, 32'd1);
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rd = m_rdata;
        e  = m_err;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [19];

    initial begin
        logic [31:0] rd, first;
        logic        e;
        int          lat, seen;

        vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h10,   32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h11,   32'h00000055, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h12,   32'h00001234, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h123455EF, 1'b0};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h13,   32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'h123455EF, 1'b0};
        vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h10,   32'h0,        32'h0,        1'b1};
        vecs[14] = '{1'b0, 2'b01, 1'b0, 32'h11,   32'h0,        32'h0,        1'b1};
        vecs[15] = '{1'b1, 2'b10, 1'b0, 32'h4000, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
        vecs[17] = '{1'b0, 2'b10, 1'b0, 32'h4010, 32'h0,        32'h123455EF, 1'b0};
        vecs[18] = '{1'b0, 2'b00, 1'b0, 32'h11,   32'h0,        32'h00000055, 1'b0};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst req_ready1", {31'b0, bus1.req_ready_o}, 32'd0);
        chk("rst req_ready4", {31'b0, bus4.req_ready_o}, 32'd0);
        chk("rst rsp_valid1", {31'b0, bus1.rsp_valid_o}, 32'd0);
        chk("rst rsp_rdata1", bus1.rsp_rdata_o, 32'd0);
        chk("rst rsp_err1",   {31'b0, bus1.rsp_err_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst req_ready1", {31'b0, bus1.req_ready_o}, 32'd1);

        // LATENCY=1 vector table.
        sel = 1'b0;
        for (int i = 0; i < 19; i++) begin
            xact(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rd, e, lat);
            chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            chk($sformatf("vec%0d latency", i), lat, 32'd1);
        end

        // LATENCY=4: store, then a load held under backpressure.
        @(posedge clk); #1;
        sel = 1'b1;
        xact(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, e, lat);
        chk("l4 sw latency", lat, 32'd4);
        chk("l4 sw err", {31'b0, e}, 32'd0);
        @(posedge clk); #1;

        we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20;
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        chk("l4 idle req_ready", {31'b0, m_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 20) begin
            chk($sformatf("l4 busy req_ready c%0d", lat), {31'b0, m_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("l4 lw latency", lat, 32'd4);
        chk("l4 lw rdata", m_rdata, 32'h11223344);
        first = m_rdata;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d rsp_valid", k), {31'b0, m_valid}, 32'd1);
            chk($sformatf("stall%0d rdata", k), m_rdata, first);
            chk($sformatf("stall%0d req_ready", k), {31'b0, m_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("handshake req_ready", {31'b0, m_ready}, 32'd0);
        @(posedge clk); #1;
        chk("after hs rsp_valid", {31'b0, m_valid}, 32'd0);
        chk("after hs req_ready", {31'b0, m_ready}, 32'd1);

        // Reset while a LATENCY=4 store is in BUSY.
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h30; wdata = 32'hAAAA5555;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid-rst rsp_valid", {31'b0, m_valid}, 32'd0);
        chk("mid-rst req_ready", {31'b0, m_ready}, 32'd0);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (m_valid) seen++;
            @(posedge clk); #1;
        end
        chk("aborted rsp count", seen, 32'd0);
        xact(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, e, lat);
        chk("aborted sw lw rdata", rd, 32'h0);
        chk("aborted sw lw latency", lat, 32'd4);
        xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, e, lat);
        chk("cleared word rdata", rd, 32'h0);
        @(posedge clk); #1;
        sel = 1'b0;
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e, lat);
        chk("l1 cleared rdata", rd, 32'h0);
        chk("l1 cleared err", {31'b0, e}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_lsu_mem.md
Name: dmem_lsu_mem

Overview:
- Parametrised successor to the single-cycle dummy data memory in the datapath's mem stage.
- Adds a valid/ready request/response handshake and configurable access latency.
- Adds RISC-V sub-word load/store support (byte/half/word, signed/unsigned load extension) and misalignment/illegal-size error reporting.
- Sits between the mem stage and a word-organised storage array; one outstanding request at a time.

Parameters:
- DEPTH_WORDS, 4096, number of DATA_W words in the array; must be a power of 2.
- LATENCY, 1, cycles from request acceptance to response valid; must be at least 1.
- DATA_W, 32, word width; fixed at 32 for this generation. Elaboration fails if any other value is given.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- req_addr_i  in  32  byte address
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  mem_size_t: 00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_wdata_i  in  32  store data; LSBs used for byte/half
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  consumer takes response
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned address or illegal size

Behaviour:
- Reset is synchronous and active-high on rst_i; single clock clk_i.
- While rst_i is high:
  - All array words are cleared to 0.
  - FSM goes to IDLE; internal counter is cleared.
  - req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Reset asserted mid-operation aborts the request: no write is committed and no response is produced.
- Word index: (req_addr_i >> 2) mod DEPTH_WORDS. Upper bits are ignored and addresses wrap.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
- Illegal size: req_size_i = 11.
- FSM has three states: IDLE, BUSY, RESP.
  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o (cycle T), capture all req fields and load the counter with LATENCY-1.
    - If LATENCY=1: perform the access in cycle T and go to RESP.
    - Otherwise: go to BUSY.
  - BUSY: req_ready_o=0. Decrement the counter each cycle. When the counter is 0, perform the access and go to RESP.
  - RESP: rsp_valid_o=1; rsp_rdata_o and rsp_err_o are held stable. On rsp_ready_i=1, go to IDLE.
    - req_ready_o stays 0 in the handshake cycle; the next request can be accepted at the earliest one cycle after the response handshake.
- Response timing: rsp_valid_o rises at T+LATENCY. Backpressure on rsp_ready_i stalls the block indefinitely with no data change.
- Access: the write is committed at the clock edge that enters RESP. Load data is the array word sampled at that same edge, before any write.
- Store byte-enables:
  - byte: lane addr[1:0] gets wdata[7:0].
  - half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - word: all lanes.
  - Untouched lanes keep their old value.
- Load extension:
  - byte: select lane addr[1:0], then extend bit 7.
  - half: select half addr[1], then extend bit 15.
  - word: no extension.
  - Extension uses sign or zero according to the captured req_unsigned_i.
- Error: no array write; rsp_err_o=1 and rsp_rdata_o=0. Latency is unchanged.
- Requests arriving while not in IDLE are ignored; the requester must hold them until ready.

Decomposition:
- tartaruga_pkg gains:
  - mem_size_t enum (MEM_BYTE, MEM_HALF, MEM_WORD, MEM_ILLEGAL).
  - DMEM_DEPTH_WORDS constant.
  - dmem_req_t struct {addr, we, size, is_unsigned, wdata}.
- One sub-module: dmem_lane_align. It is purely combinational and computes:
  - byte-enable mask and shifted store data;
  - load lane selection and extension;
  - misalignment/illegal-size error.
- The FSM, counter and array stay in the top module.

Test Plan:
- LATENCY=1: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid at T+1, rdata=0xDEADBEEF, err=0.
- After that word: LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x12 -> 0xFFFFDEAD. LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 -> 0xDEAD55EF.
- SH 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- LATENCY=4:
  - LW accepted at cycle 10 -> rsp_valid first at cycle 14.
  - Hold rsp_ready_i=0 for 3 cycles -> rsp_valid and rdata stable.
  - req_ready_o=0 from cycle 11 until one cycle after the handshake.
- SW 0x13 -> err=1, rdata=0, and the word at index 4 is unchanged. req_size_i=11 -> err=1.
- Wrap-around: SW at 0x4000 (DEPTH 4096), then LW 0x0 -> same data.
- Reset mid-BUSY: apply reset during a SW under LATENCY=4 -> no rsp_valid; a subsequent LW returns 0.
